fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Parametrised instruction-fetch front end for the next-generation core. Replaces the single IR/PC
//  load path with a PC generator, a one-outstanding-request memory port and a DEPTH-entry prefetch queue.
//  Decode pops {pc, instr} pairs through a valid/ready handshake. Branch/jump redirects flush the
//  queue and drop any in-flight fetch.
// PARAMETERS
//  XLEN      32       address / PC width
//  ILEN      32       instruction width (equals the mem_rdata width)
//  DEPTH     4        prefetch queue entries; power of 2, >= 2
//  RESET_PC  'h1000   PC of the first fetch after reset
// PORTS
//  clk             in   1                  clock, all state on rising edge
//  rst             in   1                  reset, synchronous, active-high
//  fetch_en        in   1                  permit new memory requests (stall/halt when 0)
//  mem_addr        out  XLEN               fetch address; stable while mem_read=1
//  mem_read        out  1                  fetch request; held until mem_resp
//  mem_rdata       in   ILEN               instruction word, valid when mem_resp=1
//  mem_resp        in   1                  single-cycle response; ignored while mem_read=0
//  redirect_valid  in   1                  flush queue and restart fetch at redirect_pc
//  redirect_pc     in   XLEN               new PC; bits [1:0] are forced to 0
//  instr_valid     out  1                  queue head valid
//  instr           out  ILEN               head instruction
//  instr_pc        out  XLEN               head instruction PC
//  instr_ready     in   1                  decode accepts the head this cycle
//  count           out  $clog2(DEPTH+1)    occupied queue entries
// BEHAVIOUR
//  - Reset values: mem_read=0, mem_addr=RESET_PC, instr_valid=0, count=0, state=IDLE, fetch_pc=RESET_PC.
//    instr and instr_pc are don't-care while instr_valid=0.
//  - FSM: IDLE, REQ, DISCARD.
//    IDLE->REQ when fetch_en && (count + pending_pop_adj) < DEPTH (credit: an issued request always
//    has a slot reserved). In REQ, mem_read=1 and mem_addr=fetch_pc.
//    REQ->IDLE on mem_resp: push {fetch_pc, mem_rdata} and set fetch_pc += 4. PC wraps modulo 2^XLEN.
//    The next request may issue in the cycle after the response (no back-to-back in the same cycle).
//  - Latency: if mem_resp occurs in cycle k, instr_valid=1 in cycle k+1 (queue output is read from
//    registered storage). After reset deassertion with fetch_en=1, mem_read rises in the first cycle.
//  - Pop: instr_valid && instr_ready. A push and a pop in the same cycle leave count unchanged.
//    A full queue blocks issue only; it never drops data.
//  - Redirect (highest priority) in cycle r:
//    - Flush the queue: count=0 and instr_valid=0 from r+1.
//    - fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00}.
//    - Any pop in cycle r is still a legal handshake, but the popped entry is stale.
//    - If in REQ without mem_resp: go to DISCARD. mem_read and mem_addr stay at the old address
//      until mem_resp; that data is dropped, then go to IDLE.
//    - If in REQ with mem_resp in cycle r: the data is dropped and the FSM goes to IDLE.
//    - A second redirect while in DISCARD only updates fetch_pc.
//    - The first request at the new PC issues no earlier than r+1.
//  - fetch_en=0 never aborts a request already in REQ; it only blocks new issue.
//  - rst mid-request: all state returns to reset values next cycle. A late mem_resp is ignored
//    because mem_read=0.
// STRUCTURE
//  - core_pkg: fetch_state_t enum {IDLE, REQ, DISCARD}; constant INSTR_BYTES=4; default RESET_PC
//    constant shared with the core PC logic.
//  - Sub-module sync_fifo #(WIDTH=XLEN+ILEN, DEPTH) provides push, pop, synchronous flush, count,
//    empty and full outputs, with head data read combinationally from storage. fetch_unit holds
//    the FSM, fetch_pc and the credit check.
// TESTING
//  1. Reset then fetch_en=1, mem_resp 1 cycle after every mem_read, instr_ready=1 ->
//     mem_addr sequence 'h1000, 'h1004, 'h1008; instr_pc matches each address; instr equals the
//     returned data, in order.
//  2. instr_ready=0, DEPTH=4 -> exactly 4 responses accepted, count=4, mem_read stays 0.
//     Raise instr_ready for 1 cycle -> one pop, count=3, then exactly one new request at 'h1010.
//  3. Redirect to 'h2002 while a request to 'h1008 is pending, mem_resp 3 cycles later ->
//     mem_addr holds 'h1008 until the response; the response is dropped (no instr_valid);
//     the next request is at 'h2000.
//  4. Redirect in the same cycle as mem_resp with 2 queued entries -> count=0 next cycle,
//     the response is dropped, the next fetch is at the redirect PC.
//  5. Assert rst for 1 cycle while in REQ, then mem_resp 2 cycles later -> no push; mem_read
//     re-asserts at 'h1000; count=0.
//  6. Redirect to 'hFFFF_FFFC with 2 responses -> instr_pc 'hFFFF_FFFC then 'h0000_0000 (wrap).

Source files
------------

// File: rtl/core_pkg.sv
// Shared core definitions: fetch FSM encoding and fetch-path constants.
package core_pkg;
  typedef enum logic [1:0] {IDLE, REQ, DISCARD} fetch_state_t;
  localparam int INSTR_BYTES = 4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_1000;
endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with flush; head data is read combinationally from storage.
module sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push && !flush && !rst) mem[wr_ptr] <= wdata;
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: PC generator, single-outstanding memory port, prefetch queue.
module fetch_unit
  import core_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int ILEN  = 32,
  parameter int DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEFAULT_RESET_PC)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       fetch_en,
  output logic [XLEN-1:0]            mem_addr,
  output logic                       mem_read,
  input  logic [ILEN-1:0]            mem_rdata,
  input  logic                       mem_resp,
  input  logic                       redirect_valid,
  input  logic [XLEN-1:0]            redirect_pc,
  output logic                       instr_valid,
  output logic [ILEN-1:0]            instr,
  output logic [XLEN-1:0]            instr_pc,
  input  logic                       instr_ready,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  fetch_state_t          state;
  logic [XLEN-1:0]       fetch_pc;
  logic [XLEN-1:0]       redirect_aligned;
  logic                  push, pop, fifo_empty, fifo_full, can_issue;
  logic [XLEN+ILEN-1:0]  head;

  assign redirect_aligned = redirect_pc & ~XLEN'(3);
  // A request only issues when a slot is free; nothing else pushes, so that
  // slot stays reserved until the response lands.
  assign can_issue   = fetch_en && !fifo_full;
  assign push        = (state == REQ) && mem_resp && !redirect_valid;
  assign pop         = instr_valid && instr_ready;
  assign instr_valid = !fifo_empty;
  assign {instr_pc, instr} = head;

  sync_fifo #(.WIDTH(XLEN+ILEN), .DEPTH(DEPTH)) u_queue (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .wdata ({fetch_pc, mem_rdata}),
    .rdata (head),
    .count (count),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      mem_addr <= RESET_PC;
      mem_read <= 1'b0;
    end else begin
      if (redirect_valid) fetch_pc <= redirect_aligned;
      case (state)
        IDLE: begin
          // Hold off on a redirect cycle so the first new request uses the new PC.
          if (!redirect_valid && can_issue) begin
            state    <= REQ;
            mem_read <= 1'b1;
            mem_addr <= fetch_pc;
          end
        end
        REQ: begin
          if (mem_resp) begin
            state    <= IDLE;
            mem_read <= 1'b0;
            if (!redirect_valid) fetch_pc <= fetch_pc + XLEN'(INSTR_BYTES);
          end else if (redirect_valid) begin
            state <= DISCARD;
          end
        end
        DISCARD: begin
          if (mem_resp) begin
            state    <= IDLE;
            mem_read <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: queue-level reference model, randomized memory/decode/redirect traffic.
module tb_fetch_unit;
  localparam int DEPTH = 4;
  localparam logic [31:0] RPC = 32'h1000;

  logic        clk = 1'b0, rst = 1'b1, fetch_en = 1'b0, mem_resp = 1'b0;
  logic        redirect_valid = 1'b0, instr_ready = 1'b0;
  logic [31:0] mem_rdata = '0, redirect_pc = '0;
  logic [31:0] mem_addr, instr, instr_pc;
  logic        mem_read, instr_valid;
  logic [2:0]  count;

  always #5 clk = ~clk;

  fetch_unit #(.XLEN(32), .ILEN(32), .DEPTH(DEPTH), .RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst), .fetch_en(fetch_en), .mem_addr(mem_addr), .mem_read(mem_read),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .instr_valid(instr_valid), .instr(instr),
    .instr_pc(instr_pc), .instr_ready(instr_ready), .count(count)
  );

  int checks = 0, errors = 0;
  task automatic check(string name, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  typedef struct packed { logic [31:0] pc; logic [31:0] data; } ent_t;

  // Reference model: expected queue contents and next fetch PC.
  ent_t        q[$];
  logic [31:0] exp_pc = RPC, req_addr = RPC;
  bit          stale = 0, held = 0, started = 0;
  bit          last_fe = 0, last_redir = 0, last_rst = 0, last_mr = 0;
  int          last_size = 0, idle_cnt = 0;
  logic [31:0] req_log[$];
  ent_t        pop_log[$];

  always @(posedge clk) begin
    last_fe = fetch_en; last_redir = redirect_valid; last_rst = rst;
    last_mr = mem_read; last_size = q.size();
    if (rst) begin
      q.delete(); exp_pc = RPC; stale = 0; held = 0; idle_cnt = 0; started = 1;
    end else if (started) begin
      if (!mem_read && fetch_en && !redirect_valid && q.size() < DEPTH) idle_cnt++;
      else idle_cnt = 0;
      check("issue_liveness", idle_cnt > 1, 0);
      if (instr_valid && instr_ready && !redirect_valid) pop_log.push_back({instr_pc, instr});
      if (q.size() > 0 && instr_ready) void'(q.pop_front());
      if (redirect_valid) begin
        q.delete();
        exp_pc = redirect_pc & ~32'h3;
        stale  = mem_read && !mem_resp;
      end else if (mem_read && mem_resp) begin
        if (!stale) begin
          q.push_back({exp_pc, mem_rdata});
          exp_pc = exp_pc + 32'd4;
        end
        stale = 0;
      end
      held = mem_read && !mem_resp;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      check("count", count, q.size());
      check("instr_valid", instr_valid, q.size() > 0);
      if (q.size() > 0) begin
        check("instr_pc", instr_pc, q[0].pc);
        check("instr", instr, q[0].data);
      end
      if (last_rst) begin
        check("reset_mem_read", mem_read, 0);
        check("reset_mem_addr", mem_addr, RPC);
      end
      if (mem_read) begin
        if (held) check("mem_addr_hold", mem_addr, req_addr);
        else begin
          check("mem_addr_new", mem_addr, exp_pc);
          check("issue_legal", last_fe && !last_redir && !last_rst && !last_mr && last_size < DEPTH, 1);
          req_log.push_back(mem_addr);
          req_addr = mem_addr;
        end
      end
    end
  end

  // Memory responder: per-request latency from a script, a fixed value, or random.
  int lat_script[$];
  int default_lat = 1, wait_cnt = 0;
  bit in_req = 0, force_resp = 0, rand_data = 0, spurious = 0;
  always @(negedge clk) begin
    if (mem_read) begin
      if (!in_req) begin
        in_req = 1;
        if (lat_script.size() > 0) wait_cnt = lat_script.pop_front();
        else if (default_lat < 0)  wait_cnt = int'($urandom_range(3, 0));
        else                       wait_cnt = default_lat;
      end
      if (wait_cnt == 0) begin
        mem_resp  = 1'b1;
        mem_rdata = rand_data ? $urandom : (mem_addr ^ 32'hDEAD_0000);
        in_req    = 0;
      end else begin
        wait_cnt--;
        mem_resp = 1'b0;
      end
    end else begin
      in_req    = 0;
      mem_resp  = force_resp || (spurious && $urandom_range(3, 0) == 0);
      mem_rdata = $urandom;
    end
  end

  task automatic step(int n = 1);
    repeat (n) begin @(negedge clk); #1; end
  endtask

  task automatic do_reset();
    rst = 1; fetch_en = 0; redirect_valid = 0; instr_ready = 0; force_resp = 0;
    lat_script.delete();
    step(2);
    rst = 0;
    req_log.delete(); pop_log.delete();
  endtask

  task automatic wait_reqs(int n, int budget);
    int k = 0;
    while (req_log.size() < n && k < budget) begin step(); k++; end
    check("wait_reqs_timeout", req_log.size() >= n, 1);
  endtask

  logic [31:0] t1_pc [3] = '{32'h1000, 32'h1004, 32'h1008};
  logic [31:0] t1_dat[3] = '{32'hDEAD_1000, 32'hDEAD_1004, 32'hDEAD_1008};

  initial begin
    int k;
    // Reset state and sequential fetch
    do_reset();
    check("rst_mem_read", mem_read, 0);
    check("rst_count", count, 0);
    check("rst_valid", instr_valid, 0);
    check("rst_mem_addr", mem_addr, 32'h1000);
    default_lat = 1; instr_ready = 1; fetch_en = 1;
    step(16);
    check("t1_nreq", req_log.size() >= 3, 1);
    check("t1_npop", pop_log.size() >= 3, 1);
    for (int i = 0; i < 3; i++) begin
      if (req_log.size() > i) check("t1_req_addr", req_log[i], t1_pc[i]);
      if (pop_log.size() > i) begin
        check("t1_pop_pc", pop_log[i].pc, t1_pc[i]);
        check("t1_pop_instr", pop_log[i].data, t1_dat[i]);
      end
    end

    // Full queue blocks issue; one pop frees exactly one request
    do_reset();
    default_lat = 1; fetch_en = 1;
    step(25);
    check("t2_count_full", count, 4);
    check("t2_mem_read_idle", mem_read, 0);
    check("t2_nreq", req_log.size(), 4);
    instr_ready = 1; step(); instr_ready = 0;
    check("t2_count_after_pop", count, 3);
    step(10);
    check("t2_nreq2", req_log.size(), 5);
    if (req_log.size() == 5) check("t2_refill_addr", req_log[4], 32'h1010);
    check("t2_count_refill", count, 4);

    // Redirect during a pending request
    do_reset();
    instr_ready = 1; default_lat = 1; lat_script = '{1, 1, 3}; fetch_en = 1;
    wait_reqs(3, 20);
    check("t3_pending_addr", mem_addr, 32'h1008);
    redirect_pc = 32'h2002; redirect_valid = 1; step(); redirect_valid = 0;
    check("t3_hold_read", mem_read, 1);
    check("t3_hold_addr", mem_addr, 32'h1008);
    step(3);
    check("t3_dropped_valid", instr_valid, 0);
    wait_reqs(4, 10);
    if (req_log.size() >= 4) check("t3_new_addr", req_log[3], 32'h2000);

    // Redirect in the same cycle as a response with 2 queued entries
    do_reset();
    default_lat = 1; fetch_en = 1; k = 0;
    while (!(mem_read && mem_resp && req_log.size() == 3) && k < 30) begin step(); k++; end
    check("t4_poll_timeout", k < 30, 1);
    check("t4_count_before", count, 2);
    redirect_pc = 32'h3000; redirect_valid = 1; step(); redirect_valid = 0;
    check("t4_count_flushed", count, 0);
    check("t4_valid_flushed", instr_valid, 0);
    wait_reqs(4, 10);
    if (req_log.size() >= 4) check("t4_new_addr", req_log[3], 32'h3000);

    // Reset mid-request with a late response
    do_reset();
    default_lat = 5; fetch_en = 1;
    wait_reqs(1, 10);
    check("t5_in_req", mem_read, 1);
    rst = 1; fetch_en = 0; step(); rst = 0;
    force_resp = 1; step(2); force_resp = 0;
    check("t5_count", count, 0);
    check("t5_valid", instr_valid, 0);
    check("t5_mem_read", mem_read, 0);
    default_lat = 1; fetch_en = 1;
    wait_reqs(2, 10);
    if (req_log.size() >= 2) check("t5_restart_addr", req_log[1], 32'h1000);

    // PC wrap after a redirect near the top of the address space
    do_reset();
    default_lat = -1; fetch_en = 1;
    step(3);
    redirect_pc = 32'hFFFF_FFFE; redirect_valid = 1; step(); redirect_valid = 0;
    pop_log.delete(); instr_ready = 1; k = 0;
    while (pop_log.size() < 2 && k < 40) begin step(); k++; end
    check("t6_npop", pop_log.size() >= 2, 1);
    if (pop_log.size() >= 2) begin
      check("t6_pc0", pop_log[0].pc, 32'hFFFF_FFFC);
      check("t6_pc1", pop_log[1].pc, 32'h0000_0000);
    end

    // Randomized traffic against the model
    do_reset();
    default_lat = -1; rand_data = 1; spurious = 1;
    for (int i = 0; i < 4000; i++) begin
      fetch_en       = ($urandom_range(7, 0) != 0);
      instr_ready    = ($urandom_range(4, 0) < 3);
      redirect_valid = ($urandom_range(39, 0) == 0);
      redirect_pc    = ($urandom_range(3, 0) == 0) ? (32'hFFFF_FFF0 | $urandom_range(15, 0)) : $urandom;
      rst            = ($urandom_range(499, 0) == 0);
      step();
    end
    rst = 0; redirect_valid = 0;
    step(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
